// File: rtl/moore_pkg.sv
// Shared types, the default 6-state Moore table and the helpers that seed
// the programmable tables at reset.
package moore_pkg;

   localparam int unsigned MAX_STATE_W = 8;
   localparam int unsigned MAX_IN_W    = 8;
   localparam int unsigned DEF_ROWS    = 6;

   typedef logic [MAX_STATE_W-1:0] state_t;
   typedef logic [MAX_IN_W-1:0]    in_t;

   // Rows S0..S5: {next on x=0, next on x=1}
   localparam state_t DEFAULT_NEXT [DEF_ROWS][2] = '{
      '{8'd1, 8'd2},
      '{8'd1, 8'd3},
      '{8'd2, 8'd4},
      '{8'd5, 8'd0},
      '{8'd5, 8'd0},
      '{8'd0, 8'd0}
   };

   localparam logic DEFAULT_OUT [DEF_ROWS] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   // The default table applies only to the 1-bit-input, >=6-state shape;
   // every other row loops on itself.
   function automatic state_t default_next(input state_t s, input in_t x,
                                           input int unsigned num_states,
                                           input int unsigned in_w);
      if (in_w == 1 && num_states >= DEF_ROWS && 32'(s) < DEF_ROWS) begin
         return DEFAULT_NEXT[s[2:0]][x[0]];
      end
      return s;
   endfunction

   function automatic logic default_out(input state_t s, input int unsigned num_states,
                                        input int unsigned in_w);
      if (in_w == 1 && num_states >= DEF_ROWS && 32'(s) < DEF_ROWS) begin
         return DEFAULT_OUT[s[2:0]];
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/moore_prog_fsm_if.sv
// Step/config/observation bundle of moore_prog_fsm; the sequencer is the slave.
interface moore_prog_fsm_if #(
   parameter int unsigned STATE_W = 3,
   parameter int unsigned IN_W    = 1,
   parameter int unsigned OUT_W   = 1,
   parameter int unsigned DWELL_W = 8
);
   logic               en;
   logic [IN_W-1:0]    x;
   logic [OUT_W-1:0]   y;
   logic [STATE_W-1:0] state_o;
   logic               cfg_ns_we;
   logic               cfg_out_we;
   logic [STATE_W-1:0] cfg_state;
   logic [IN_W-1:0]    cfg_in;
   logic [STATE_W-1:0] cfg_next;
   logic [OUT_W-1:0]   cfg_out;
   logic               cfg_err;
   logic [DWELL_W-1:0] dwell;

   modport master (
      output en, x, cfg_ns_we, cfg_out_we, cfg_state, cfg_in, cfg_next, cfg_out,
      input  y, state_o, cfg_err, dwell
   );

   modport slave (
      input  en, x, cfg_ns_we, cfg_out_we, cfg_state, cfg_in, cfg_next, cfg_out,
      output y, state_o, cfg_err, dwell
   );
endinterface

// File: rtl/moore_tbl.sv
// Register-resident next-state and output tables: async reset to the default
// table, one write port, combinational read.
module moore_tbl
   import moore_pkg::*;
#(
   parameter int unsigned NUM_STATES = 6,
   parameter int unsigned STATE_W    = 3,
   parameter int unsigned IN_W       = 1,
   parameter int unsigned OUT_W      = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ns_we,
   input  logic               out_we,
   input  logic [STATE_W-1:0] wr_state,
   input  logic [IN_W-1:0]    wr_in,
   input  logic [STATE_W-1:0] wr_next,
   input  logic [OUT_W-1:0]   wr_out,
   input  logic [STATE_W-1:0] rd_state,
   input  logic [IN_W-1:0]    rd_in,
   output logic [STATE_W-1:0] rd_next,
   output logic [OUT_W-1:0]   rd_out
);

   localparam int unsigned NUM_IN = 2 ** IN_W;
   localparam int unsigned IDX_W  = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;

   logic [STATE_W-1:0] next_q [NUM_STATES][NUM_IN];
   logic [OUT_W-1:0]   out_q  [NUM_STATES];

   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   // Callers only present legal rows, so the narrow index never aliases.
   assign wr_idx = wr_state[IDX_W-1:0];
   assign rd_idx = rd_state[IDX_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_STATES; s++) begin
            out_q[s] <= OUT_W'(default_out(state_t'(s), NUM_STATES, IN_W));
            for (int i = 0; i < NUM_IN; i++) begin
               next_q[s][i] <= STATE_W'(default_next(state_t'(s), in_t'(i), NUM_STATES, IN_W));
            end
         end
      end else begin
         if (ns_we) begin
            next_q[wr_idx][wr_in] <= wr_next;
         end
         if (out_we) begin
            out_q[wr_idx] <= wr_out;
         end
      end
   end

   always_comb begin
      rd_next = next_q[rd_idx][rd_in];
      rd_out  = out_q[rd_idx];
   end

endmodule

// File: rtl/moore_prog_fsm.sv
// Table-driven Moore sequencer with run-time rewritable tables.
// Optional dwell counter enabled by defining MOORE_DWELL_EN.
module moore_prog_fsm
   import moore_pkg::*;
#(
   parameter int unsigned NUM_STATES = 6,
   parameter int unsigned STATE_W    = 3,
   parameter int unsigned IN_W       = 1,
   parameter int unsigned OUT_W      = 1,
   parameter int unsigned DWELL_W    = 8
) (
   input logic              clk,
   input logic              reset,
   moore_prog_fsm_if.slave  bus
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [STATE_W-1:0] tbl_next;
   logic [OUT_W-1:0]   tbl_out;
   logic               cfg_req;
   logic               cfg_bad;
   logic               cfg_err_q;

   assign cfg_req = bus.cfg_ns_we | bus.cfg_out_we;
   // A bad row or a bad next-state target drops both halves of the write.
   assign cfg_bad = (32'(bus.cfg_state) >= NUM_STATES) ||
                    (bus.cfg_ns_we && (32'(bus.cfg_next) >= NUM_STATES));

   moore_tbl #(
      .NUM_STATES (NUM_STATES),
      .STATE_W    (STATE_W),
      .IN_W       (IN_W),
      .OUT_W      (OUT_W)
   ) u_tbl (
      .clk      (clk),
      .reset    (reset),
      .ns_we    (bus.cfg_ns_we & ~cfg_bad),
      .out_we   (bus.cfg_out_we & ~cfg_bad),
      .wr_state (bus.cfg_state),
      .wr_in    (bus.cfg_in),
      .wr_next  (bus.cfg_next),
      .wr_out   (bus.cfg_out),
      .rd_state (state_q),
      .rd_in    (bus.x),
      .rd_next  (tbl_next),
      .rd_out   (tbl_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.en) begin
         state_d = tbl_next;
      end
   end

   always_comb begin
      bus.y       = tbl_out;
      bus.state_o = state_q;
      bus.cfg_err = cfg_err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_req & cfg_bad;
      end
   end

`ifdef MOORE_DWELL_EN
   logic [DWELL_W-1:0] dwell_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dwell_q <= '0;
      end else if (state_d != state_q) begin
         dwell_q <= '0;
      end else if (dwell_q != '1) begin
         dwell_q <= dwell_q + DWELL_W'(1);
      end
   end

   assign bus.dwell = dwell_q;
`else
   assign bus.dwell = DWELL_W'(0);
`endif

   a_state_legal : assert property (@(posedge clk) disable iff (reset)
      32'(state_q) < NUM_STATES)
      else $error("moore_prog_fsm: illegal state %0d", state_q);

endmodule

// File: tb/tb_moore_prog_fsm.sv
// Directed self-checking bench for moore_prog_fsm; honours MOORE_DWELL_EN.
module tb_moore_prog_fsm;

   localparam int unsigned NS = 6;
   localparam int unsigned SW = 3;
   localparam int unsigned IW = 1;
   localparam int unsigned OW = 1;
`ifdef MOORE_DWELL_EN
   localparam int unsigned DW = 2;
`else
   localparam int unsigned DW = 8;
`endif

   logic clk = 1'b0;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   moore_prog_fsm_if #(.STATE_W(SW), .IN_W(IW), .OUT_W(OW), .DWELL_W(DW)) bus ();

   moore_prog_fsm #(
      .NUM_STATES (NS),
      .STATE_W    (SW),
      .IN_W       (IW),
      .OUT_W      (OW),
      .DWELL_W    (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic xv);
      bus.en = 1'b1;
      bus.x  = xv;
      tick();
      bus.en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      vecs++; if (bus.state_o !== 3'd0) begin errs++; $display("FAIL reset state: got %0d want 0", bus.state_o); end
      vecs++; if (bus.y !== 1'b0) begin errs++; $display("FAIL reset y: got %0d want 0", bus.y); end
      vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL reset cfg_err: got %0d want 0", bus.cfg_err); end
      vecs++; if (bus.dwell !== '0) begin errs++; $display("FAIL reset dwell: got %0d want 0", bus.dwell); end
   endtask

   task automatic test_golden();
      logic       xs [2][5] = '{'{1'b0, 1'b0, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
      logic [2:0] st [2][5] = '{'{3'd1, 3'd1, 3'd3, 3'd5, 3'd0}, '{3'd2, 3'd2, 3'd4, 3'd5, 3'd0}};
      logic       ys [5]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 5; i++) begin
            step(xs[s][i]);
            vecs++;
            if (bus.state_o !== st[s][i]) begin
               errs++; $display("FAIL golden%0d[%0d] state: got %0d want %0d", s, i, bus.state_o, st[s][i]);
            end
            vecs++;
            if (bus.y !== ys[i]) begin
               errs++; $display("FAIL golden%0d[%0d] y: got %0d want %0d", s, i, bus.y, ys[i]);
            end
         end
      end
   endtask

   task automatic test_hold();
      step(1'b0);
      vecs++; if (bus.state_o !== 3'd1) begin errs++; $display("FAIL hold entry state: got %0d want 1", bus.state_o); end
      for (int i = 0; i < 3; i++) begin
         bus.en = 1'b0;
         bus.x  = ~bus.x;
         tick();
         vecs++; if (bus.state_o !== 3'd1) begin errs++; $display("FAIL hold[%0d] state: got %0d want 1", i, bus.state_o); end
         vecs++; if (bus.y !== 1'b1) begin errs++; $display("FAIL hold[%0d] y: got %0d want 1", i, bus.y); end
      end
      step(1'b1);
      step(1'b1);
      vecs++; if (bus.state_o !== 3'd0) begin errs++; $display("FAIL hold exit state: got %0d want 0", bus.state_o); end
   endtask

   task automatic test_cfg_bypass();
      bus.cfg_ns_we = 1'b1;
      bus.cfg_state = 3'd0;
      bus.cfg_in    = 1'b1;
      bus.cfg_next  = 3'd5;
      step(1'b1);
      bus.cfg_ns_we = 1'b0;
      vecs++; if (bus.state_o !== 3'd2) begin errs++; $display("FAIL bypass old entry: got %0d want 2", bus.state_o); end
      vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL bypass cfg_err: got %0d want 0", bus.cfg_err); end
      step(1'b1);
      step(1'b1);
      vecs++; if (bus.state_o !== 3'd0) begin errs++; $display("FAIL bypass return: got %0d want 0", bus.state_o); end
      step(1'b1);
      vecs++; if (bus.state_o !== 3'd5) begin errs++; $display("FAIL bypass new entry: got %0d want 5", bus.state_o); end
      vecs++; if (bus.y !== 1'b1) begin errs++; $display("FAIL bypass new y: got %0d want 1", bus.y); end
      step(1'b0);
   endtask

   task automatic test_reject();
      // Row out of range
      bus.cfg_ns_we = 1'b1; bus.cfg_state = 3'd6; bus.cfg_in = 1'b0; bus.cfg_next = 3'd1;
      tick();
      bus.cfg_ns_we = 1'b0;
      vecs++; if (bus.cfg_err !== 1'b1) begin errs++; $display("FAIL rej_row err: got %0d want 1", bus.cfg_err); end
      tick();
      vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL rej_row err clear: got %0d want 0", bus.cfg_err); end
      // Next-state target out of range
      bus.cfg_ns_we = 1'b1; bus.cfg_state = 3'd0; bus.cfg_in = 1'b0; bus.cfg_next = 3'd7;
      tick();
      bus.cfg_ns_we = 1'b0;
      vecs++; if (bus.cfg_err !== 1'b1) begin errs++; $display("FAIL rej_next err: got %0d want 1", bus.cfg_err); end
      tick();
      vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL rej_next err clear: got %0d want 0", bus.cfg_err); end
      // Combined write with a bad target: the output half must be dropped too
      bus.cfg_ns_we = 1'b1; bus.cfg_out_we = 1'b1;
      bus.cfg_state = 3'd3; bus.cfg_in = 1'b0; bus.cfg_next = 3'd6; bus.cfg_out = 1'b1;
      tick();
      bus.cfg_ns_we = 1'b0; bus.cfg_out_we = 1'b0;
      vecs++; if (bus.cfg_err !== 1'b1) begin errs++; $display("FAIL rej_both err: got %0d want 1", bus.cfg_err); end
      step(1'b0);
      vecs++; if (bus.state_o !== 3'd1) begin errs++; $display("FAIL rej row0 intact: got %0d want 1", bus.state_o); end
      vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL rej_both err clear: got %0d want 0", bus.cfg_err); end
      step(1'b1);
      vecs++; if (bus.y !== 1'b0) begin errs++; $display("FAIL rej out3 intact: got %0d want 0", bus.y); end
      step(1'b0);
      vecs++; if (bus.state_o !== 3'd5) begin errs++; $display("FAIL rej row3 intact: got %0d want 5", bus.state_o); end
      step(1'b0);
      // Accepted output write
      bus.cfg_out_we = 1'b1; bus.cfg_state = 3'd3; bus.cfg_out = 1'b1;
      tick();
      bus.cfg_out_we = 1'b0;
      vecs++; if (bus.cfg_err !== 1'b0) begin errs++; $display("FAIL out write err: got %0d want 0", bus.cfg_err); end
      step(1'b0);
      step(1'b1);
      vecs++; if (bus.state_o !== 3'd3) begin errs++; $display("FAIL out write state: got %0d want 3", bus.state_o); end
      vecs++; if (bus.y !== 1'b1) begin errs++; $display("FAIL out write y: got %0d want 1", bus.y); end
      step(1'b1);
   endtask

   task automatic test_reset_restore();
      logic [DW-1:0] dw_exp [5];
`ifdef MOORE_DWELL_EN
      dw_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
      dw_exp = '{default: '0};
`endif
      step(1'b0);
      step(1'b0);
`ifdef MOORE_DWELL_EN
      vecs++; if (bus.dwell !== DW'(1)) begin errs++; $display("FAIL dwell stay: got %0d want 1", bus.dwell); end
`else
      vecs++; if (bus.dwell !== '0) begin errs++; $display("FAIL dwell tied: got %0d want 0", bus.dwell); end
`endif
      #2;
      reset = 1'b1;
      #1;
      vecs++; if (bus.state_o !== 3'd0) begin errs++; $display("FAIL async reset state: got %0d want 0", bus.state_o); end
      vecs++; if (bus.dwell !== '0) begin errs++; $display("FAIL async reset dwell: got %0d want 0", bus.dwell); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vecs++;
         if (bus.dwell !== dw_exp[i]) begin
            errs++; $display("FAIL dwell[%0d]: got %0d want %0d", i, bus.dwell, dw_exp[i]);
         end
      end
      vecs++; if (bus.state_o !== 3'd0) begin errs++; $display("FAIL dwell hold state: got %0d want 0", bus.state_o); end
      step(1'b1);
      vecs++; if (bus.state_o !== 3'd2) begin errs++; $display("FAIL restored row0: got %0d want 2", bus.state_o); end
      vecs++; if (bus.dwell !== '0) begin errs++; $display("FAIL dwell change: got %0d want 0", bus.dwell); end
      step(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b1);
      vecs++; if (bus.state_o !== 3'd3) begin errs++; $display("FAIL restore path: got %0d want 3", bus.state_o); end
      vecs++; if (bus.y !== 1'b0) begin errs++; $display("FAIL restored out3: got %0d want 0", bus.y); end
      step(1'b1);
   endtask

   initial begin
      reset          = 1'b1;
      bus.en         = 1'b0;
      bus.x          = 1'b0;
      bus.cfg_ns_we  = 1'b0;
      bus.cfg_out_we = 1'b0;
      bus.cfg_state  = '0;
      bus.cfg_in     = '0;
      bus.cfg_next   = '0;
      bus.cfg_out    = '0;
      test_reset();
      test_golden();
      test_hold();
      test_cfg_bypass();
      test_reject();
      test_reset_restore();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
